multi_channel_counter_core: RTL and testbench
=============================================

Name: multi_channel_counter_core

Overview:
Parametrised N-channel up/down counter peripheral core. Each channel has its own count, reload and compare registers, a selectable mode (free-run, auto-reload, one-shot) and a sticky interrupt status bit. A bus master programs one channel at a time through a channel-select register port. All per-channel interrupt requests are combined into a single registered irq_out.

Parameters:
NUM_CH, 4, number of counter channels (1..16)
WIDTH, 32, counter/reload/compare width in bits (8..64)
LT_THRESH, 1000, threshold for the per-channel "count less than threshold" status flag
CH_W, $clog2(NUM_CH) (min 1), channel-select width (derived, not overridable)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ch_sel  in  CH_W  channel addressed by all writes and by the *_out read ports
count_we  in  1  load count_in into the selected channel's count
count_in  in  WIDTH  count load value
config_we  in  1  load en_in/dir_in/ire_in/mode_in into the selected channel
en_in, dir_in, ire_in  in  1 each  enable, direction (1 = up), interrupt enable
mode_in  in  2  0 = FREE, 1 = RELOAD, 2 = ONESHOT, 3 = reserved (behaves as FREE)
reload_we / reload_in  in  1 / WIDTH  write the reload value
compare_we / compare_in  in  1 / WIDTH  write the compare value
status_clr_we / status_clr_in  in  1 / NUM_CH  write-1-to-clear of the sticky status bits
count_out, reload_out, compare_out  out  WIDTH each  selected channel's registers
en_out, dir_out, ire_out  out  1 each  selected channel's config
mode_out  out  2  selected channel's mode
lt_out  out  1  selected channel's registered (count < LT_THRESH) flag
irq_status_out  out  NUM_CH  sticky status, all channels
irq_out  out  1  registered OR over all channels of (status & ire)

Behaviour:
- Reset (synchronous): count = 0, reload = 0, en = 0, dir = 0, ire = 0, mode = FREE, lt = 0, status = 0, irq_out = 0. Compare resets to all-ones.
- Read outputs are combinational muxes of the registers, indexed by ch_sel. irq_status_out and irq_out are not muxed.
- Writes change only channel ch_sel and are visible one cycle later. Write enables of different registers may assert together.
- Count update per channel, highest priority first:
  1. count_we on this channel: load count_in.
  2. en = 1: step by ±1 (modulo 2^WIDTH) and apply the terminal-count (TC) rules below.
  3. Otherwise: hold.
- TC condition, evaluated on the current count while en = 1 and no count_we:
  - Up: count == reload in RELOAD/ONESHOT; count == all-ones in FREE.
  - Down: count == 0 in all modes.
- Action at TC:
  - FREE: wrap naturally.
  - RELOAD: up loads 0, down loads reload.
  - ONESHOT: count holds, and en clears next cycle unless config_we to this channel occurs in the same cycle (the config write wins).
- Compare match: en = 1 and count == compare, evaluated on the current count.
- Status: the bit is set the cycle after a TC or a match. If set and status_clr_in[i] occur in the same cycle, set wins. The status bit is set regardless of ire.
- irq_out is a register of |(status & ire). An event in cycle N sets status at N+1 and raises irq_out at N+2. irq_out stays high while any enabled status bit remains set (level, not pulse).
- lt is registered as count < LT_THRESH (unsigned), one cycle behind count. If LT_THRESH ≥ 2^WIDTH, lt is constant 1 after the first clock.
- Reset during counting returns all state to reset values at that clock edge; pending events are lost.
- An out-of-range ch_sel (≥ NUM_CH): writes are ignored and reads return 0.

Decomposition:
- Package counter_pkg: mode_e enum (MODE_FREE, MODE_RELOAD, MODE_ONESHOT, MODE_RSVD), and the channel config struct {en, dir, ire, mode}.
- Sub-module counter_channel (parameter WIDTH, LT_THRESH): holds the count, reload, compare, config and lt registers for one channel, and outputs single-cycle tc and match pulses.
- The top level generates NUM_CH counter_channel instances and contains the write decode, read mux, status register and irq_out register.

Test Plan:
1. Reset, then read every channel -> all registers 0 except compare = all-ones; irq_out = 0 and irq_status_out = 0.
2. ch 1: reload = 5, mode RELOAD, dir up, en -> count_out sequence 0,1,2,3,4,5,0,1…; status[1] set the cycle after each count == 5; with ire = 1, irq_out high 2 cycles after the first TC.
3. ch 2: count = 3, mode ONESHOT, dir down, en -> 3,2,1,0,0…; en_out = 0 the cycle after count == 0; status[2] = 1.
4. ch 0: compare = 10, FREE up from 8 -> status[0] set on the match. Write-1-to-clear in the same cycle as the next match (count 10 again after re-load to 8) -> bit stays 1. A later clear with no event -> bit 0, and irq_out 0 one cycle later.
5. ch 3: FREE up, count = all-ones -> wraps to 0 and status[3] sets. Then count_we in the same cycle as counting -> the loaded value wins.
6. lt flag with LT_THRESH = 1000: count = 999 held (en = 0) -> lt_out = 1; count = 1000 -> lt_out = 0 one cycle after count_out changes.

Source files
------------

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_pkg
// Purpose  : Shared types for the multi-channel counter core: counting modes
//            and the per-channel configuration word.
// Revision : 1.0 - initial release
// ============================================================================
package counter_pkg;

  // Counting mode. The reserved encoding behaves as free-run.
  typedef enum logic [1:0] {
    MODE_FREE    = 2'd0,
    MODE_RELOAD  = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  // Per-channel configuration word.
  typedef struct packed {
    logic  en;
    logic  dir;
    logic  ire;
    mode_e mode;
  } ch_cfg_t;

  localparam ch_cfg_t c_CFG_RESET = '{en: 1'b0, dir: 1'b0, ire: 1'b0, mode: MODE_FREE};

endpackage
`default_nettype wire

// File: rtl/counter_channel.sv
`default_nettype none
// ============================================================================
// Module   : counter_channel
// Purpose  : One up/down counter channel with reload, compare, config and
//            registered less-than-threshold flag. Emits combinational tc and
//            match indications, valid for the current count.
// Revision : 1.0 - initial release
// ============================================================================
module counter_channel
  import counter_pkg::*;
#(
  parameter int              WIDTH     = 32,
  parameter longint unsigned LT_THRESH = 64'd1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             count_we_i,
  input  logic [WIDTH-1:0] count_in_i,
  input  logic             config_we_i,
  input  ch_cfg_t          cfg_i,
  input  logic             reload_we_i,
  input  logic [WIDTH-1:0] reload_in_i,
  input  logic             compare_we_i,
  input  logic [WIDTH-1:0] compare_in_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] reload_o,
  output logic [WIDTH-1:0] compare_o,
  output ch_cfg_t          cfg_o,
  output logic             lt_o,
  output logic             tc_o,
  output logic             match_o
);

  localparam logic [WIDTH-1:0] c_ALL_ONES = '1;

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] compare_q;
  ch_cfg_t          cfg_q, cfg_d;
  logic             lt_q;

  logic             w_bounded;
  logic             w_tc;
  logic [WIDTH-1:0] w_step;

  // Terminal-count detection and next count/config; a count load overrides counting.
  always_comb begin
    w_bounded = (cfg_q.mode == MODE_RELOAD) || (cfg_q.mode == MODE_ONESHOT);
    w_step    = cfg_q.dir ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
    w_tc      = 1'b0;
    if (cfg_q.en && !count_we_i) begin
      if (cfg_q.dir) begin
        w_tc = w_bounded ? (count_q == reload_q) : (count_q == c_ALL_ONES);
      end else begin
        w_tc = (count_q == '0);
      end
    end

    count_d = count_q;
    if (count_we_i) begin
      count_d = count_in_i;
    end else if (cfg_q.en) begin
      if (w_tc && (cfg_q.mode == MODE_RELOAD)) begin
        count_d = cfg_q.dir ? '0 : reload_q;
      end else if (w_tc && (cfg_q.mode == MODE_ONESHOT)) begin
        count_d = count_q;
      end else begin
        count_d = w_step;
      end
    end

    // A one-shot stops itself at terminal count unless software rewrites config.
    cfg_d = cfg_q;
    if (config_we_i) begin
      cfg_d = cfg_i;
    end else if (w_tc && (cfg_q.mode == MODE_ONESHOT)) begin
      cfg_d.en = 1'b0;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      reload_q  <= '0;
      compare_q <= c_ALL_ONES;
      cfg_q     <= c_CFG_RESET;
      lt_q      <= 1'b0;
    end else begin
      count_q <= count_d;
      cfg_q   <= cfg_d;
      lt_q    <= (64'(count_q) < LT_THRESH);
      if (reload_we_i) begin
        reload_q <= reload_in_i;
      end
      if (compare_we_i) begin
        compare_q <= compare_in_i;
      end
    end
  end

  assign count_o   = count_q;
  assign reload_o  = reload_q;
  assign compare_o = compare_q;
  assign cfg_o     = cfg_q;
  assign lt_o      = lt_q;
  assign tc_o      = w_tc;
  assign match_o   = cfg_q.en && (count_q == compare_q);

endmodule
`default_nettype wire

// File: rtl/multi_channel_counter_core.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_counter_core
// Purpose  : N-channel counter peripheral core: write decode by channel
//            select, read mux, sticky per-channel status and registered irq.
// Revision : 1.0 - initial release
// ============================================================================
module multi_channel_counter_core
  import counter_pkg::*;
#(
  parameter int              NUM_CH    = 4,
  parameter int              WIDTH     = 32,
  parameter longint unsigned LT_THRESH = 64'd1000,
  localparam int             CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic              count_we,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              config_we,
  input  logic              en_in,
  input  logic              dir_in,
  input  logic              ire_in,
  input  logic [1:0]        mode_in,
  input  logic              reload_we,
  input  logic [WIDTH-1:0]  reload_in,
  input  logic              compare_we,
  input  logic [WIDTH-1:0]  compare_in,
  input  logic              status_clr_we,
  input  logic [NUM_CH-1:0] status_clr_in,
  output logic [WIDTH-1:0]  count_out,
  output logic [WIDTH-1:0]  reload_out,
  output logic [WIDTH-1:0]  compare_out,
  output logic              en_out,
  output logic              dir_out,
  output logic              ire_out,
  output logic [1:0]        mode_out,
  output logic              lt_out,
  output logic [NUM_CH-1:0] irq_status_out,
  output logic              irq_out
);

  logic [WIDTH-1:0]  w_count   [NUM_CH];
  logic [WIDTH-1:0]  w_reload  [NUM_CH];
  logic [WIDTH-1:0]  w_compare [NUM_CH];
  ch_cfg_t           w_cfg     [NUM_CH];
  logic [NUM_CH-1:0] w_lt;
  logic [NUM_CH-1:0] w_evt;
  logic [NUM_CH-1:0] w_ire;
  ch_cfg_t           w_cfg_in;

  logic [NUM_CH-1:0] status_q, status_d;
  logic              irq_q;

  assign w_cfg_in = '{en: en_in, dir: dir_in, ire: ire_in, mode: mode_e'(mode_in)};

  // One counter per channel; an out-of-range select matches no channel.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic w_hit;
    logic w_tc;
    logic w_match;

    assign w_hit = (ch_sel == CH_W'(i));

    counter_channel #(
      .WIDTH     (WIDTH),
      .LT_THRESH (LT_THRESH)
    ) u_channel (
      .clk          (clk),
      .reset        (reset),
      .count_we_i   (count_we && w_hit),
      .count_in_i   (count_in),
      .config_we_i  (config_we && w_hit),
      .cfg_i        (w_cfg_in),
      .reload_we_i  (reload_we && w_hit),
      .reload_in_i  (reload_in),
      .compare_we_i (compare_we && w_hit),
      .compare_in_i (compare_in),
      .count_o      (w_count[i]),
      .reload_o     (w_reload[i]),
      .compare_o    (w_compare[i]),
      .cfg_o        (w_cfg[i]),
      .lt_o         (w_lt[i]),
      .tc_o         (w_tc),
      .match_o      (w_match)
    );

    assign w_evt[i] = w_tc || w_match;
    assign w_ire[i] = w_cfg[i].ire;
  end

  // Read mux of the selected channel; returns zero for an unmapped select.
  always_comb begin
    count_out   = '0;
    reload_out  = '0;
    compare_out = '0;
    en_out      = 1'b0;
    dir_out     = 1'b0;
    ire_out     = 1'b0;
    mode_out    = 2'd0;
    lt_out      = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == CH_W'(i)) begin
        count_out   = w_count[i];
        reload_out  = w_reload[i];
        compare_out = w_compare[i];
        en_out      = w_cfg[i].en;
        dir_out     = w_cfg[i].dir;
        ire_out     = w_cfg[i].ire;
        mode_out    = w_cfg[i].mode;
        lt_out      = w_lt[i];
      end
    end
  end

  // Sticky status: a new event beats a simultaneous write-1-to-clear.
  always_comb begin
    status_d = status_q & ~(status_clr_we ? status_clr_in : '0);
    status_d = status_d | w_evt;
  end

  // Status and level interrupt registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      irq_q    <= |(status_q & w_ire);
    end
  end

  assign irq_status_out = status_q;
  assign irq_out        = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_counter_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_channel_counter_core
// Purpose  : Directed self-checking bench for multi_channel_counter_core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_channel_counter_core;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        ch_sel;
  logic              count_we;
  logic [WIDTH-1:0]  count_in;
  logic              config_we;
  logic              en_in, dir_in, ire_in;
  logic [1:0]        mode_in;
  logic              reload_we;
  logic [WIDTH-1:0]  reload_in;
  logic              compare_we;
  logic [WIDTH-1:0]  compare_in;
  logic              status_clr_we;
  logic [NUM_CH-1:0] status_clr_in;
  logic [WIDTH-1:0]  count_out, reload_out, compare_out;
  logic              en_out, dir_out, ire_out;
  logic [1:0]        mode_out;
  logic              lt_out;
  logic [NUM_CH-1:0] irq_status_out;
  logic              irq_out;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multi_channel_counter_core #(
    .NUM_CH    (NUM_CH),
    .WIDTH     (WIDTH),
    .LT_THRESH (64'd1000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ch_sel         (ch_sel),
    .count_we       (count_we),
    .count_in       (count_in),
    .config_we      (config_we),
    .en_in          (en_in),
    .dir_in         (dir_in),
    .ire_in         (ire_in),
    .mode_in        (mode_in),
    .reload_we      (reload_we),
    .reload_in      (reload_in),
    .compare_we     (compare_we),
    .compare_in     (compare_in),
    .status_clr_we  (status_clr_we),
    .status_clr_in  (status_clr_in),
    .count_out      (count_out),
    .reload_out     (reload_out),
    .compare_out    (compare_out),
    .en_out         (en_out),
    .dir_out        (dir_out),
    .ire_out        (ire_out),
    .mode_out       (mode_out),
    .lt_out         (lt_out),
    .irq_status_out (irq_status_out),
    .irq_out        (irq_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_count(input logic [1:0] ch, input logic [WIDTH-1:0] v);
    ch_sel = ch; count_we = 1'b1; count_in = v;
    step();
    count_we = 1'b0;
  endtask

  task automatic wr_reload(input logic [1:0] ch, input logic [WIDTH-1:0] v);
    ch_sel = ch; reload_we = 1'b1; reload_in = v;
    step();
    reload_we = 1'b0;
  endtask

  task automatic wr_compare(input logic [1:0] ch, input logic [WIDTH-1:0] v);
    ch_sel = ch; compare_we = 1'b1; compare_in = v;
    step();
    compare_we = 1'b0;
  endtask

  task automatic wr_cfg(input logic [1:0] ch, input logic en, input logic dir,
                        input logic ire, input logic [1:0] mode);
    ch_sel = ch; config_we = 1'b1;
    en_in = en; dir_in = dir; ire_in = ire; mode_in = mode;
    step();
    config_we = 1'b0;
  endtask

  task automatic clr_status(input logic [NUM_CH-1:0] bits);
    status_clr_we = 1'b1; status_clr_in = bits;
    step();
    status_clr_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ch_sel = '0;
    count_we = 1'b0; count_in = '0;
    config_we = 1'b0; en_in = 1'b0; dir_in = 1'b0; ire_in = 1'b0; mode_in = 2'd0;
    reload_we = 1'b0; reload_in = '0;
    compare_we = 1'b0; compare_in = '0;
    status_clr_we = 1'b0; status_clr_in = '0;

    // 1. Reset state of every channel
    step(); step();
    reset = 1'b0;
    check("rst_lt", 64'(lt_out), 64'd0);
    check("rst_irq", 64'(irq_out), 64'd0);
    check("rst_status", 64'(irq_status_out), 64'd0);
    for (int c = 0; c < NUM_CH; c++) begin
      ch_sel = 2'(c);
      #1;
      check("rst_count", 64'(count_out), 64'd0);
      check("rst_reload", 64'(reload_out), 64'd0);
      check("rst_compare", 64'(compare_out), 64'hFFFF_FFFF);
      check("rst_cfg", 64'({en_out, dir_out, ire_out, mode_out}), 64'd0);
    end

    // 2. ch1 auto-reload up to 5, interrupt enabled
    wr_reload(2'd1, 32'd5);
    wr_cfg(2'd1, 1'b1, 1'b1, 1'b1, 2'd1);
    check("t2_reload", 64'(reload_out), 64'd5);
    for (int k = 0; k < 8; k++) begin
      check("t2_count", 64'(count_out), 64'(k % 6));
      if (k == 5) check("t2_status_pre", 64'(irq_status_out), 64'h0);
      if (k == 6) begin
        check("t2_status_set", 64'(irq_status_out), 64'h2);
        check("t2_irq_pre", 64'(irq_out), 64'd0);
      end
      if (k == 7) check("t2_irq_set", 64'(irq_out), 64'd1);
      step();
    end
    wr_cfg(2'd1, 1'b0, 1'b1, 1'b0, 2'd1);
    clr_status(4'hF);
    check("t2_status_clr", 64'(irq_status_out), 64'h0);
    step();
    check("t2_irq_clr", 64'(irq_out), 64'd0);

    // 3. ch2 one-shot down from 3
    wr_count(2'd2, 32'd3);
    wr_cfg(2'd2, 1'b1, 1'b0, 1'b0, 2'd2);
    check("t3_c3", 64'(count_out), 64'd3);
    step(); check("t3_c2", 64'(count_out), 64'd2);
    step(); check("t3_c1", 64'(count_out), 64'd1);
    step(); check("t3_c0", 64'(count_out), 64'd0);
    check("t3_en_still", 64'(en_out), 64'd1);
    step();
    check("t3_hold", 64'(count_out), 64'd0);
    check("t3_en_clr", 64'(en_out), 64'd0);
    check("t3_status", 64'(irq_status_out), 64'h4);
    step();
    check("t3_hold2", 64'(count_out), 64'd0);
    check("t3_irq_masked", 64'(irq_out), 64'd0);
    clr_status(4'hF);

    // 4. ch0 compare match, set beats clear, then plain clear
    wr_compare(2'd0, 32'd10);
    wr_count(2'd0, 32'd8);
    wr_cfg(2'd0, 1'b1, 1'b1, 1'b1, 2'd0);
    check("t4_c8", 64'(count_out), 64'd8);
    step(); step();
    check("t4_c10", 64'(count_out), 64'd10);
    check("t4_status_pre", 64'(irq_status_out), 64'h0);
    step();
    check("t4_c11", 64'(count_out), 64'd11);
    check("t4_status_set", 64'(irq_status_out), 64'h1);
    step();
    check("t4_irq", 64'(irq_out), 64'd1);
    wr_count(2'd0, 32'd8);
    step(); step();
    check("t4_c10b", 64'(count_out), 64'd10);
    clr_status(4'h1);
    check("t4_set_wins", 64'(irq_status_out), 64'h1);
    step();
    clr_status(4'h1);
    check("t4_clr", 64'(irq_status_out), 64'h0);
    check("t4_irq_hold", 64'(irq_out), 64'd1);
    step();
    check("t4_irq_drop", 64'(irq_out), 64'd0);
    wr_cfg(2'd0, 1'b0, 1'b0, 1'b0, 2'd0);

    // 5. ch3 free-run wrap and load-over-count priority
    wr_compare(2'd3, 32'd100);
    wr_count(2'd3, 32'hFFFF_FFFF);
    wr_cfg(2'd3, 1'b1, 1'b1, 1'b0, 2'd0);
    check("t5_ones", 64'(count_out), 64'hFFFF_FFFF);
    step();
    check("t5_wrap", 64'(count_out), 64'd0);
    check("t5_status", 64'(irq_status_out), 64'h8);
    wr_count(2'd3, 32'd50);
    check("t5_load_wins", 64'(count_out), 64'd50);
    step();
    check("t5_c51", 64'(count_out), 64'd51);

    // 6. lt flag around the threshold
    wr_cfg(2'd3, 1'b0, 1'b1, 1'b0, 2'd0);
    wr_count(2'd3, 32'd999);
    step();
    check("t6_c999", 64'(count_out), 64'd999);
    check("t6_lt999", 64'(lt_out), 64'd1);
    wr_count(2'd3, 32'd1000);
    check("t6_c1000", 64'(count_out), 64'd1000);
    check("t6_lt_lag", 64'(lt_out), 64'd1);
    step();
    check("t6_lt1000", 64'(lt_out), 64'd0);

    // 7. reset while counting
    wr_cfg(2'd1, 1'b1, 1'b1, 1'b0, 2'd0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    ch_sel = 2'd1;
    #1;
    check("t7_count", 64'(count_out), 64'd0);
    check("t7_en", 64'(en_out), 64'd0);
    check("t7_status", 64'(irq_status_out), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
